instr_fetch: RTL and testbench

Instruction fetch unit: the consumer of the program counter's address output and the producer of its enable. It reads the word at `pc_addr` from instruction memory over a req/ack handshake and pulses `pc_enable` once per accepted word, which advances the PC. It checks odd parity and presents the word to the decoder over a valid/ready handshake. It sits between `pc`, instruction memory and the instruction decoder.

---
 rtl/apollo_pkg.sv | 21 ++
 rtl/instr_fetch_odd_parity_chk.sv | 9 +
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apollo_pkg.sv
// Shared constants, fetch FSM encoding and odd-parity helpers for the apollo fetch path.
package apollo_pkg;
    localparam int ADDR_W = 12;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // High when a stored word (parity bit included) has an even number of ones.
    function automatic logic odd_parity_err(input logic [WORD_W-1:0] word);
        return ~^word;
    endfunction

    // Parity bit the memory write path places in the top bit so the stored word is odd.
    function automatic logic odd_parity_bit(input logic [WORD_W-2:0] payload);
        return ~^payload;
    endfunction
endpackage

// File: rtl/instr_fetch_odd_parity_chk.sv
// Combinational odd-parity check: err is high when the word holds an even number of ones.
module odd_parity_chk #(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0] data,
    output logic              err
);
    assign err = ~^data;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads the word at the PC over req/ack, advances the PC once per
// accepted word and holds the word, its address and a parity flag for the decoder.
module instr_fetch #(
    parameter int ADDR_W   = apollo_pkg::ADDR_W,
    parameter int WORD_W   = apollo_pkg::WORD_W,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_enable,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-2:0] instr_word,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              parity_err,
    output logic              fetch_timeout
);
    import apollo_pkg::*;

    localparam int              CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    fetch_state_t      r_state;
    logic [CNT_W-1:0]  r_wait;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-2:0] r_instr_word;
    logic [ADDR_W-1:0] r_instr_addr;
    logic              r_parity_err;

    logic w_in_req;
    logic w_accept;
    logic w_timeout;
    logic w_rdata_err;

    odd_parity_chk #(
        .WORD_W (WORD_W)
    ) u_parity (
        .data (mem_rdata),
        .err  (w_rdata_err)
    );

    // Ack and timeout are qualified by flush so a jump never advances the PC.
    assign w_in_req  = (r_state == REQ);
    assign w_accept  = w_in_req && mem_ack && !flush;
    assign w_timeout = w_in_req && !mem_ack && !flush && (r_wait == WAIT_LAST);

    assign pc_enable     = w_accept;
    assign fetch_timeout = w_timeout;
    assign mem_req       = w_in_req;
    assign mem_addr      = r_mem_addr;
    assign instr_valid   = (r_state == HOLD);
    assign instr_word    = r_instr_word;
    assign instr_addr    = r_instr_addr;
    assign parity_err    = r_parity_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wait       <= '0;
            r_mem_addr   <= '0;
            r_instr_word <= '0;
            r_instr_addr <= '0;
            r_parity_err <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mem_addr <= pc_addr;
                    r_wait     <= '0;
                    r_state    <= REQ;
                end
                REQ: begin
                    if (mem_ack) begin
                        r_instr_word <= mem_rdata[WORD_W-2:0];
                        r_instr_addr <= r_mem_addr;
                        r_parity_err <= w_rdata_err;
                        r_wait       <= '0;
                        r_state      <= HOLD;
                    end else if (w_timeout) begin
                        r_wait  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // The PC already advanced on the ack edge, so pc_addr is the next word.
                    if (instr_ready) begin
                        r_mem_addr <= pc_addr;
                        r_wait     <= '0;
                        r_state    <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: the bench acts as PC, instruction memory and decoder.
module tb_instr_fetch;
    localparam int ADDR_W   = 12;
    localparam int WORD_W   = 16;
    localparam int MAX_WAIT = 8;
    localparam int NEVER    = 1000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] pc_addr = '0;
    logic              pc_enable;
    logic              flush = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [WORD_W-2:0] instr_word;
    logic [ADDR_W-1:0] instr_addr;
    logic              parity_err;
    logic              fetch_timeout;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W   (ADDR_W),
        .WORD_W   (WORD_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_addr       (pc_addr),
        .pc_enable     (pc_enable),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_word    (instr_word),
        .instr_addr    (instr_addr),
        .parity_err    (parity_err),
        .fetch_timeout (fetch_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory image, program counter, open request and held word.
    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] pc;
    bit                req_active, exp_valid, hs_prev;
    logic [ADDR_W-1:0] req_addr, held_addr;
    logic [WORD_W-2:0] held_word;
    bit                held_perr;
    int                req_cycles, req_wait, idle_run, delivered;

    int wait_mode    = -1;
    int ready_pct    = 100;
    int flush_pct    = 0;
    int junk_pct     = 0;
    bit flush_on_ack = 1'b0;
    int flush_target = -1;

    bit                s_req, s_pcen, s_valid, s_tmo, s_flush, s_perr;
    logic [ADDR_W-1:0] s_addr, s_iaddr;
    logic [WORD_W-2:0] s_word;

    function automatic bit perr_of(input logic [WORD_W-1:0] w);
        return ($countones(w) % 2) == 0;
    endfunction

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(99));
        if (wait_mode >= 0) return wait_mode;
        if (r < 45) return 0;
        if (r < 85) return int'($urandom_range(1, 4));
        if (r < 92) return MAX_WAIT - 1;
        return NEVER;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        mem_ack = 1'b0;
        instr_ready = 1'b0;
        pc = '0;
        pc_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        req_active = 1'b0;
        exp_valid = 1'b0;
        hs_prev = 1'b0;
        idle_run = 0;
    endtask

    task automatic run_cycle(input bit force_flush);
        bit exp_pcen, exp_tmo;
        @(negedge clk);
        instr_ready = (int'($urandom_range(99)) < ready_pct);
        mem_ack = 1'b0;
        mem_rdata = WORD_W'($urandom);
        if (req_active) chk("req_held", mem_req, 1);
        if (exp_valid) chk("no_req_in_hold", mem_req, 0);
        if (hs_prev) chk("req_after_accept", mem_req, 1);
        if (mem_req && !req_active && !exp_valid) begin
            req_active = 1'b1;
            req_addr = mem_addr;
            req_cycles = 0;
            req_wait = pick_wait();
            chk("fetch_addr", mem_addr, pc);
        end
        if (req_active) begin
            chk("addr_stable", mem_addr, req_addr);
            if (req_cycles >= req_wait) begin
                mem_ack = 1'b1;
                mem_rdata = mem[req_addr];
            end
        end else begin
            mem_ack = (int'($urandom_range(99)) < junk_pct);
        end
        flush = force_flush || (flush_on_ack && mem_ack && req_active)
                || (int'($urandom_range(99)) < flush_pct);
        #1;
        exp_pcen = req_active && mem_ack && !flush;
        exp_tmo = req_active && !mem_ack && !flush && (req_cycles == MAX_WAIT - 1);
        chk("pc_enable", pc_enable, exp_pcen);
        chk("fetch_timeout", fetch_timeout, exp_tmo);
        chk("instr_valid", instr_valid, exp_valid);
        if (exp_valid) begin
            chk("instr_word", instr_word, held_word);
            chk("instr_addr", instr_addr, held_addr);
            chk("parity_err", parity_err, held_perr);
        end
        if (!mem_req && !exp_valid) idle_run++;
        else idle_run = 0;
        chk("idle_gap", (idle_run <= 1), 1);
        if (flush) idle_run = 0;
        s_req = mem_req; s_addr = mem_addr; s_pcen = pc_enable; s_valid = instr_valid;
        s_tmo = fetch_timeout; s_flush = flush; s_word = instr_word;
        s_iaddr = instr_addr; s_perr = parity_err;

        @(posedge clk);
        #1;
        if (flush) begin
            exp_valid = 1'b0;
            req_active = 1'b0;
            hs_prev = 1'b0;
            pc = (flush_target >= 0) ? ADDR_W'(flush_target) : ADDR_W'($urandom);
        end else begin
            hs_prev = exp_valid && instr_ready;
            if (hs_prev) begin
                exp_valid = 1'b0;
                delivered++;
            end
            if (req_active) begin
                if (mem_ack) begin
                    exp_valid = 1'b1;
                    held_word = mem[req_addr][WORD_W-2:0];
                    held_addr = req_addr;
                    held_perr = perr_of(mem[req_addr]);
                    req_active = 1'b0;
                    pc = pc + 1'b1;
                end else if (req_cycles == MAX_WAIT - 1) begin
                    req_active = 1'b0;
                end else begin
                    req_cycles++;
                end
            end
        end
        pc_addr = pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n_req, n_pcen, n_valid;
        bit  found;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = WORD_W'($urandom);

        // Reset state, with a stray ack present.
        #2 reset = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_pc_enable", pc_enable, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_word", instr_word, 0);
        chk("rst_instr_addr", instr_addr, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_fetch_timeout", fetch_timeout, 0);
        mem_ack = 1'b0;

        // Zero-wait memory, decoder always ready.
        mem[0] = 16'h8001;
        wait_mode = 0; ready_pct = 100; junk_pct = 0;
        do_reset();
        run_cycle(0);
        chk("a_c0_req", s_req, 0);
        run_cycle(0);
        chk("a_c1_req", s_req, 1);
        chk("a_c1_addr", s_addr, 0);
        chk("a_c1_pcen", s_pcen, 1);
        run_cycle(0);
        chk("a_c2_valid", s_valid, 1);
        chk("a_c2_word", s_word, 15'h0001);
        chk("a_c2_iaddr", s_iaddr, 0);
        chk("a_c2_perr", s_perr, 1);
        run_cycle(0);
        chk("a_c3_req", s_req, 1);
        chk("a_c3_addr", s_addr, 1);

        // Three wait states.
        mem[0] = 16'h0001;
        wait_mode = 3;
        do_reset();
        n_req = 0; n_pcen = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            run_cycle(0);
            n_req += int'(s_req);
            n_pcen += int'(s_pcen);
            found = s_valid;
        end
        chk("b_valid_seen", found, 1);
        chk("b_req_cycles", n_req, 4);
        chk("b_pcen_count", n_pcen, 1);
        chk("b_perr", s_perr, 0);

        // Decoder stalls for five cycles in HOLD.
        wait_mode = 0; ready_pct = 0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            run_cycle(0);
            found = s_valid;
        end
        chk("c_valid_seen", found, 1);
        n_req = 0; n_pcen = 0; n_valid = 0;
        repeat (5) begin
            run_cycle(0);
            n_req += int'(s_req);
            n_pcen += int'(s_pcen);
            n_valid += int'(s_valid);
        end
        chk("c_stall_valid", n_valid, 5);
        chk("c_stall_req", n_req, 0);
        chk("c_stall_pcen", n_pcen, 0);
        ready_pct = 100;
        run_cycle(0);
        run_cycle(0);
        chk("c_next_req", s_req, 1);
        chk("c_next_addr", s_addr, 1);

        // Memory never answers.
        wait_mode = NEVER;
        do_reset();
        n_req = 0; n_pcen = 0; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle(0);
            n_req += int'(s_req);
            n_pcen += int'(s_pcen);
            found = s_tmo;
        end
        chk("d_timeout_seen", found, 1);
        chk("d_req_cycles", n_req, MAX_WAIT);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            run_cycle(0);
            n_pcen += int'(s_pcen);
            found = s_req;
        end
        chk("d_retry_seen", found, 1);
        chk("d_retry_addr", s_addr, 0);
        chk("d_no_pcen", n_pcen, 0);

        // Flush coincident with ack, jump to 0xAAA.
        wait_mode = 2; flush_on_ack = 1'b1; flush_target = 12'hAAA;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            run_cycle(0);
            found = s_flush;
        end
        chk("e_flush_seen", found, 1);
        chk("e_flush_pcen", s_pcen, 0);
        flush_on_ack = 1'b0; flush_target = -1;
        n_valid = 0; found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            run_cycle(0);
            n_valid += int'(s_valid);
            found = s_req;
        end
        chk("e_refetch_seen", found, 1);
        chk("e_refetch_addr", s_addr, 12'hAAA);
        chk("e_no_valid", n_valid, 0);

        // Asynchronous reset between edges while requesting.
        wait_mode = NEVER;
        do_reset();
        repeat (3) run_cycle(0);
        #2;
        chk("f_pre_req", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("f_async_req", mem_req, 0);
        chk("f_async_valid", instr_valid, 0);
        chk("f_async_addr", mem_addr, 0);
        wait_mode = 0;
        do_reset();
        run_cycle(0);
        chk("f_restart_idle", s_req, 0);
        run_cycle(0);
        chk("f_restart_req", s_req, 1);
        chk("f_restart_addr", s_addr, 0);

        // Randomized traffic.
        wait_mode = -1; junk_pct = 20; delivered = 0;
        for (int blk = 0; blk < 6; blk++) begin
            ready_pct = int'($urandom_range(20, 100));
            flush_pct = int'($urandom_range(0, 6));
            for (int i = 0; i < 500; i++) run_cycle(0);
        end
        chk("random_progress", (delivered > 150), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
